rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single write port of the 64x64 register file (r0 reads as zero) among NREQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- The winner is registered into an output stage that drives the register-file write port, HCLK domain.
- Exposes the in-flight write (valid + address) so read-side logic can detect a pending-write hazard.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 6, register address width (64 entries).
- DW, 64, data width.

Ports:
- HCLK  input  1  clock.
- HRESETn  input  1  async active-low reset.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  NREQ*AW  packed destination register; requester i occupies bits [i*AW +: AW].
- req_data  input  NREQ*DW  packed write data, same packing as req_addr.
- req_ready  output  NREQ  one-hot accept, combinational.
- arb_hold  input  1  blocks new grants while high.
- rf_wr  output  1  register-file write enable.
- rf_rw  output  AW  register-file write address.
- rf_dw  output  DW  register-file write data.
- wr_pend  output  1  output stage holds an accepted request, including r0 drops.
- grant_id  output  $clog2(NREQ)  index of requester in output stage.

Behaviour:
- Reset (async, HRESETn=0): rf_wr=0, rf_rw=0, rf_dw=0, wr_pend=0, grant_id=0, RR pointer=0, lock state cleared. Reset takes effect immediately, mid-cycle. Any accepted-but-unwritten request is lost.
- Arbitration is combinational each cycle:
  - Search starts at pointer p and wraps modulo NREQ; the first i with req_valid[i]=1 wins.
  - req_ready[i]=1 only for the winner; all zero if arb_hold=1 or no valid.
- Handshake: a transfer occurs when req_valid[i]&req_ready[i] at a rising HCLK. Requesters hold valid/addr/data stable until accepted. The arbiter never depends on that, because ready is re-evaluated each cycle.
- Output stage is always able to accept, since the register-file write completes in one cycle, so no backpressure from the output.
- On transfer at edge N:
  - rf_rw/rf_dw/grant_id load the winner's fields; wr_pend=1 during cycle N+1.
  - rf_wr=1 during cycle N+1 unless addr==0. r0 writes are accepted and consumed but rf_wr stays 0.
  - The data is visible at the register-file read ports from cycle N+2.
- With no transfer at an edge: wr_pend=0 and rf_wr=0 next cycle; rf_rw/rf_dw hold their last values.
- Pointer update, only on transfer: p <= winner+1, wrapping NREQ-1 -> 0.
- Back-to-back transfers are allowed every cycle, giving a throughput of 1 write/cycle.
- Fairness bound: a continuously valid requester is granted within NREQ cycles when arb_hold=0.
- arb_hold asserted mid-stream: the in-flight output stage still completes its write and the pointer is unchanged.
- Same-address writes from different requesters in consecutive cycles are applied in grant order; the last one wins.

Optional Feature:
- Macro: RF_WRITE_ARBITER_LOCK_EN.
- Enabled:
  - Adds input req_lock [NREQ].
  - A transfer from requester i with req_lock[i]=1 sets lock owner=i. While the lock is held, the pointer is forced to i and only i may be granted, even if others are valid.
  - The lock is released on the first transfer from i with req_lock[i]=0, or on reset.
  - arb_hold still blocks grants.
- Disabled: the port is absent and arbitration is pure round-robin as above.

Decomposition:
- Package rf_arb_pkg:
  - RF_AW=6, RF_DW=64, RF_DEPTH=64, RF_ZERO_REG=6'd0.
  - Function for one-hot to index.
- Sub-module rf_rr_arbiter:
  - Parameterised NREQ.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and winner index.
  - Pure combinational.
- The top module owns the pointer, the lock state and the output register.

Test Plan:
- Reset/idle: HRESETn=0 then 1 with all valids 0 -> rf_wr=0, wr_pend=0, req_ready=0 for 10 cycles.
- Single write:
  - Stimulus: req 2 valid, addr=5, data=64'hDEAD_BEEF.
  - Response: req_ready[2]=1 same cycle. Next cycle rf_wr=1, rf_rw=5, rf_dw=DEAD_BEEF, grant_id=2.
- Round-robin:
  - Stimulus: all 4 valid continuously for 8 cycles, pointer 0.
  - Response: grant order 0,1,2,3,0,1,2,3 and rf_wr every cycle.
- r0 drop:
  - Stimulus: req 1 valid, addr=0, data=all ones.
  - Response: req_ready[1]=1, next cycle wr_pend=1, rf_wr=0.
- Hold and async reset:
  - Stimulus: arb_hold=1 with req 0 valid.
  - Response: no ready.
  - Stimulus: release arb_hold, accept, then pull HRESETn low mid-cycle N+1.
  - Response: rf_wr drops immediately and the pointer returns to 0.
- Lock (RF_WRITE_ARBITER_LOCK_EN):
  - Stimulus: req 3 sends 3 transfers with req_lock=1,1,0 while req 0 is valid throughout.
  - Response: grants 3,3,3 then 0.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int RF_AW    = 6;
    localparam int RF_DW    = 64;
    localparam int RF_DEPTH = 64;
    localparam logic [RF_AW-1:0] RF_ZERO_REG = 6'd0;

    // Encodes a one-hot vector (up to 8 requesters) into its bit index.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rf_rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
module rf_rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0] rot_s;
    logic [NREQ-1:0] oh_rot_s;
    logic [NREQ-1:0] grant_s;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign rot_s    = NREQ'({req, req} >> ptr);
    assign oh_rot_s = rot_s & (~rot_s + NREQ'(1));
    assign grant_s  = en ? NREQ'(({oh_rot_s, oh_rot_s} << ptr) >> NREQ) : {NREQ{1'b0}};

    assign grant = grant_s;
    assign idx   = IW'(onehot_to_idx(8'(grant_s)));

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with a registered write stage.
// Optional requester lock is enabled by defining RF_WRITE_ARBITER_LOCK_EN.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               arb_hold,
`ifdef RF_WRITE_ARBITER_LOCK_EN
    input  logic [NREQ-1:0]    req_lock,
`endif
    output logic               rf_wr,
    output logic [AW-1:0]      rf_rw,
    output logic [DW-1:0]      rf_dw,
    output logic               wr_pend,
    output logic [IW-1:0]      grant_id
);

    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   arb_ptr_s;
    logic [NREQ-1:0] arb_req_s;
    logic [NREQ-1:0] grant_s;
    logic [IW-1:0]   win_s;
    logic [IW-1:0]   next_ptr_s;
    logic [AW-1:0]   win_addr_s;
    logic [DW-1:0]   win_data_s;
    logic            xfer_s;

`ifdef RF_WRITE_ARBITER_LOCK_EN
    logic            lock_act_r;
    logic [IW-1:0]   lock_own_r;

    // While a lock is held only the owner competes and the search starts at it.
    always_comb begin
        if (lock_act_r) begin
            arb_ptr_s = lock_own_r;
            arb_req_s = req_valid & (NREQ'(1) << lock_own_r);
        end else begin
            arb_ptr_s = ptr_r;
            arb_req_s = req_valid;
        end
    end
`else
    assign arb_ptr_s = ptr_r;
    assign arb_req_s = req_valid;
`endif

    rf_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (arb_req_s),
        .ptr   (arb_ptr_s),
        .en    (~arb_hold),
        .grant (grant_s),
        .idx   (win_s)
    );

    assign req_ready  = grant_s;
    assign xfer_s     = |grant_s;
    assign win_addr_s = req_addr[win_s*AW +: AW];
    assign win_data_s = req_data[win_s*DW +: DW];
    assign next_ptr_s = (win_s == IW'(NREQ-1)) ? {IW{1'b0}} : win_s + IW'(1);

    // Output stage, RR pointer and lock owner; r0 targets are consumed without a write strobe.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rf_wr      <= 1'b0;
            rf_rw      <= {AW{1'b0}};
            rf_dw      <= {DW{1'b0}};
            wr_pend    <= 1'b0;
            grant_id   <= {IW{1'b0}};
            ptr_r      <= {IW{1'b0}};
`ifdef RF_WRITE_ARBITER_LOCK_EN
            lock_act_r <= 1'b0;
            lock_own_r <= {IW{1'b0}};
`endif
        end else begin
            wr_pend <= xfer_s;
            rf_wr   <= xfer_s && (win_addr_s != AW'(RF_ZERO_REG));
            if (xfer_s) begin
                rf_rw    <= win_addr_s;
                rf_dw    <= win_data_s;
                grant_id <= win_s;
                ptr_r    <= next_ptr_s;
`ifdef RF_WRITE_ARBITER_LOCK_EN
                lock_act_r <= req_lock[win_s];
                lock_own_r <= win_s;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter against a behavioural round-robin model.
module tb_rf_write_arbiter;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [3:0]   req_valid;
    logic [23:0]  req_addr;
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic         arb_hold;
`ifdef RF_WRITE_ARBITER_LOCK_EN
    logic [3:0]   req_lock;
`endif
    logic         rf_wr;
    logic [5:0]   rf_rw;
    logic [63:0]  rf_dw;
    logic         wr_pend;
    logic [1:0]   grant_id;

    int total = 0;
    int bad   = 0;

    int         m_ptr;
    bit         m_lock_act;
    int         m_lock_own;
    logic       e_wr, e_pend;
    logic [5:0] e_rw;
    logic [63:0] e_dw;
    logic [1:0] e_gid;
    logic [3:0] exp_ready, obs_ready;
    logic [63:0] model_rf [64];
    logic [63:0] dut_rf   [64];

    always #5 HCLK = ~HCLK;

    rf_write_arbiter dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .arb_hold  (arb_hold),
`ifdef RF_WRITE_ARBITER_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rf_wr     (rf_wr),
        .rf_rw     (rf_rw),
        .rf_dw     (rf_dw),
        .wr_pend   (wr_pend),
        .grant_id  (grant_id)
    );

    task automatic clear_inputs();
        req_valid = 4'b0000;
        req_addr  = 24'd0;
        req_data  = 256'd0;
        arb_hold  = 1'b0;
`ifdef RF_WRITE_ARBITER_LOCK_EN
        req_lock  = 4'b0000;
`endif
    endtask

    task automatic set_req(input int i, input logic [5:0] a, input logic [63:0] d);
        req_addr[i*6 +: 6]  = a;
        req_data[i*64 +: 64] = d;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_lock_act = 1'b0; m_lock_own = 0;
        e_wr = 1'b0; e_pend = 1'b0; e_rw = 6'd0; e_dw = 64'd0; e_gid = 2'd0;
    endtask

    // Winner per the rules: hold blocks; lock restricts to owner; else first valid from pointer.
    function automatic int model_winner();
        if (arb_hold) return -1;
        if (m_lock_act) return req_valid[m_lock_own] ? m_lock_own : -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // Called at edge+1; samples ready before the next edge, advances the model, returns at edge+1.
    task automatic step();
        int w;
        #3;
        w = model_winner();
        exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        obs_ready = req_ready;
        @(posedge HCLK);
        if (w >= 0) begin
            e_pend = 1'b1;
            e_rw   = req_addr[w*6 +: 6];
            e_dw   = req_data[w*64 +: 64];
            e_wr   = (e_rw != 6'd0);
            e_gid  = w[1:0];
            m_ptr  = (w + 1) % 4;
`ifdef RF_WRITE_ARBITER_LOCK_EN
            m_lock_act = req_lock[w];
            m_lock_own = w;
`endif
        end else begin
            e_pend = 1'b0;
            e_wr   = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        HRESETn = 1'b0;
        model_reset();
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        HRESETn = 1'b0;
        model_reset();
        #12;
        total++;
        if ({rf_wr, wr_pend, rf_rw, rf_dw, grant_id, req_ready} !== 78'd0) begin
            bad++;
            $display("FAIL reset_vals got wr=%b pend=%b rw=%0d dw=%h gid=%0d rdy=%b exp all zero",
                     rf_wr, wr_pend, rf_rw, rf_dw, grant_id, req_ready);
        end
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if ({rf_wr, wr_pend, obs_ready} !== 6'd0) begin
                bad++;
                $display("FAIL idle c=%0d got wr=%b pend=%b rdy=%b exp 0 0 0000", c, rf_wr, wr_pend, obs_ready);
            end
        end
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(2, 6'd5, 64'hDEAD_BEEF);
        req_valid = 4'b0100;
        step();
        total++;
        if ({obs_ready, rf_wr, wr_pend, rf_rw, rf_dw, grant_id} !== {4'b0100, 1'b1, 1'b1, 6'd5, 64'hDEAD_BEEF, 2'd2}) begin
            bad++;
            $display("FAIL single got rdy=%b wr=%b pend=%b rw=%0d dw=%h gid=%0d exp rdy=0100 wr=1 pend=1 rw=5 dw=deadbeef gid=2",
                     obs_ready, rf_wr, wr_pend, rf_rw, rf_dw, grant_id);
        end
        req_valid = 4'b0000;
        step();
        total++;
        if ({rf_wr, wr_pend, rf_rw, rf_dw} !== {1'b0, 1'b0, 6'd5, 64'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL idle_hold got wr=%b pend=%b rw=%0d dw=%h exp wr=0 pend=0 rw=5 dw=deadbeef",
                     rf_wr, wr_pend, rf_rw, rf_dw);
        end
    endtask

    task automatic test_r0_drop();
        set_req(1, 6'd0, {64{1'b1}});
        req_valid = 4'b0010;
        step();
        total++;
        if ({obs_ready, wr_pend, rf_wr, grant_id} !== {4'b0010, 1'b1, 1'b0, 2'd1}) begin
            bad++;
            $display("FAIL r0_drop got rdy=%b pend=%b wr=%b gid=%0d exp rdy=0010 pend=1 wr=0 gid=1",
                     obs_ready, wr_pend, rf_wr, grant_id);
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 6'(i + 10), 64'(64'h1000 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            total++;
            if ({obs_ready, rf_wr, grant_id, rf_rw, rf_dw} !== {exp_ready, 1'b1, 2'(k % 4), e_rw, e_dw}) begin
                bad++;
                $display("FAIL rr k=%0d got rdy=%b wr=%b gid=%0d rw=%0d dw=%h exp rdy=%b wr=1 gid=%0d rw=%0d dw=%h",
                         k, obs_ready, rf_wr, grant_id, rf_rw, rf_dw, exp_ready, k % 4, e_rw, e_dw);
            end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_hold_reset();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 6'(i + 20), 64'(64'hA0 + i));
        arb_hold  = 1'b1;
        req_valid = 4'b0001;
        step();
        total++;
        if ({obs_ready, wr_pend} !== 5'd0) begin
            bad++;
            $display("FAIL hold got rdy=%b pend=%b exp rdy=0000 pend=0", obs_ready, wr_pend);
        end
        arb_hold = 1'b0;
        step();
        total++;
        if ({obs_ready, rf_wr, grant_id} !== {4'b0001, 1'b1, 2'd0}) begin
            bad++;
            $display("FAIL hold_release got rdy=%b wr=%b gid=%0d exp rdy=0001 wr=1 gid=0", obs_ready, rf_wr, grant_id);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        model_reset();
        total++;
        if ({rf_wr, wr_pend, rf_rw} !== 8'd0) begin
            bad++;
            $display("FAIL async_rst got wr=%b pend=%b rw=%0d exp 0 0 0", rf_wr, wr_pend, rf_rw);
        end
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        req_valid = 4'b1111;
        step();
        total++;
        if ({obs_ready, grant_id} !== {4'b0001, 2'd0}) begin
            bad++;
            $display("FAIL ptr_after_rst got rdy=%b gid=%0d exp rdy=0001 gid=0", obs_ready, grant_id);
        end
        req_valid = 4'b0000;
        step();
    endtask

`ifdef RF_WRITE_ARBITER_LOCK_EN
    task automatic test_lock();
        logic [2:0] lock_seq;
        lock_seq = 3'b011;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 6'(i + 30), 64'(64'hC0 + i));
        req_valid = 4'b0100;
        step();
        req_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            req_lock = {lock_seq[k], 3'b000};
            step();
            total++;
            if ({obs_ready, grant_id} !== {4'b1000, 2'd3}) begin
                bad++;
                $display("FAIL lock k=%0d got rdy=%b gid=%0d exp rdy=1000 gid=3", k, obs_ready, grant_id);
            end
        end
        req_lock = 4'b0000;
        step();
        total++;
        if ({obs_ready, grant_id} !== {4'b0001, 2'd0}) begin
            bad++;
            $display("FAIL unlock got rdy=%b gid=%0d exp rdy=0001 gid=0", obs_ready, grant_id);
        end
        req_valid = 4'b0000;
        step();
    endtask
`endif

    task automatic test_random();
        for (int a = 0; a < 64; a++) begin
            model_rf[a] = 64'd0;
            dut_rf[a]   = 64'd0;
        end
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            arb_hold  = ($urandom_range(0, 7) == 0);
`ifdef RF_WRITE_ARBITER_LOCK_EN
            req_lock  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
`endif
            for (int i = 0; i < 4; i++) set_req(i, 6'($urandom_range(0, 7)), {$urandom, $urandom});
            step();
            if (e_wr) model_rf[e_rw] = e_dw;
            if (rf_wr) dut_rf[rf_rw] = rf_dw;
            total++;
            if ({obs_ready, rf_wr, wr_pend, rf_rw, rf_dw, grant_id} !== {exp_ready, e_wr, e_pend, e_rw, e_dw, e_gid}) begin
                bad++;
                $display("FAIL rand c=%0d got rdy=%b wr=%b pend=%b rw=%0d dw=%h gid=%0d exp rdy=%b wr=%b pend=%b rw=%0d dw=%h gid=%0d",
                         c, obs_ready, rf_wr, wr_pend, rf_rw, rf_dw, grant_id,
                         exp_ready, e_wr, e_pend, e_rw, e_dw, e_gid);
            end
        end
        for (int a = 0; a < 8; a++) begin
            total++;
            if (dut_rf[a] !== model_rf[a]) begin
                bad++;
                $display("FAIL rf_contents r%0d got %h exp %h", a, dut_rf[a], model_rf[a]);
            end
        end
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_r0_drop();
        test_round_robin();
        test_hold_reset();
`ifdef RF_WRITE_ARBITER_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
